// File: rtl/mp64_mul_pkg.sv
// mp64 multiply/MAC pipeline: shared op encodings and stage payload.
// Payload fields are sized for the widest legal configuration.
package mp64_mul_pkg;

  localparam int OP_ACC = 2;

  localparam logic [1:0] SM_UU = 2'b00;
  localparam logic [1:0] SM_SS = 2'b01;
  localparam logic [1:0] SM_SU = 2'b10;

  localparam int LAT_MIN = 2;
  localparam int LAT_MAX = 8;

  localparam int MAX_W     = 64;
  localparam int MAX_TAG_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [2:0]             op;
    logic                   ovf;
    logic [MAX_TAG_W-1:0]   tag;
    logic [2*MAX_W-1:0]     c;
    logic [2*MAX_W-1:0]     result;
  } stage_t;

  function automatic logic is_signed_acc(
    input logic [1:0] sm
  );
    return (sm == SM_SS) || (sm == SM_SU);
  endfunction

endpackage

// File: rtl/mp64_mul_if.sv
// mp64 multiply/MAC pipeline: issue and result handshake bundle.
// master drives operations and out_ready; slave is the pipeline.
interface mp64_mul_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [2*WIDTH-1:0] in_c;
  logic [TAG_W-1:0]   in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_result;
  logic               out_ovf;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b,
    output in_c, in_tag, out_ready,
    input  in_ready, out_valid,
    input  out_result, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b,
    input  in_c, in_tag, out_ready,
    output in_ready, out_valid,
    output out_result, out_ovf, out_tag
  );

endinterface

// File: rtl/mp64_pipe_reg.sv
// mp64 multiply/MAC pipeline: one enable-gated payload stage.
// flush kills the valid bit only; data is left in place.
module mp64_pipe_reg
  import mp64_mul_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   flush,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mp64_mul_pipe.sv
// mp64 multiply/MAC pipeline: extend+multiply, accumulate, delay chain.
// All stages advance together; a stalled output freezes the whole pipe.
module mp64_mul_pipe
  import mp64_mul_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 4,
  parameter int TAG_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  output logic busy,
  mp64_mul_if.slave bus
);

  localparam int PW  = 2 * MAX_W;
  localparam int RW  = 2 * WIDTH;
  localparam int PRW = 2 * WIDTH + 2;
  localparam int ND  = (LATENCY > 2) ? LATENCY - 2 : 1;

  stage_t s0_d, s0_q;
  stage_t s1_d, s1_q;
  stage_t dly [ND];
  stage_t last;
  logic   pipe_en;
  logic   unused;

  assign pipe_en      = !last.valid | bus.out_ready;
  assign bus.in_ready = pipe_en & !flush;

  logic [1:0] sm;
  logic       a_sgn;
  logic       b_sgn;

  always_comb begin
    sm    = bus.in_op[1:0];
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (1'b1)
      (sm == SM_SS): begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      (sm == SM_SU): a_sgn = 1'b1;
      default: ;
    endcase
  end

  logic signed [WIDTH:0] a_x, b_x;
  logic signed [PRW-1:0] a_w, b_w, prod;

  assign a_x  = {a_sgn & bus.in_a[WIDTH-1], bus.in_a};
  assign b_x  = {b_sgn & bus.in_b[WIDTH-1], bus.in_b};
  assign a_w  = PRW'(a_x);
  assign b_w  = PRW'(b_x);
  assign prod = a_w * b_w;

  always_comb begin
    s0_d        = '0;
    s0_d.valid  = bus.in_valid & bus.in_ready;
    s0_d.op     = bus.in_op;
    s0_d.tag    = MAX_TAG_W'(bus.in_tag);
    s0_d.c      = PW'(bus.in_c);
    s0_d.result = PW'(prod[RW-1:0]);
  end

  logic [RW-1:0] p1, c1;
  logic [RW:0]   sum;

  assign p1  = s0_q.result[RW-1:0];
  assign c1  = s0_q.c[RW-1:0];
  assign sum = {1'b0, p1} + {1'b0, c1};

  always_comb begin
    s1_d     = s0_q;
    s1_d.ovf = 1'b0;
    if (s0_q.op[OP_ACC]) begin
      s1_d.result = PW'(sum[RW-1:0]);
      if (is_signed_acc(s0_q.op[1:0])) begin
        s1_d.ovf = (p1[RW-1] == c1[RW-1]) &&
                   (sum[RW-1] != p1[RW-1]);
      end else begin
        s1_d.ovf = sum[RW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
    end else if (flush) begin
      s0_q.valid <= 1'b0;
      s1_q.valid <= 1'b0;
    end else if (pipe_en) begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  for (genvar i = 0; i < LATENCY - 2; i++) begin : g_dly
    stage_t d_in;
    if (i == 0) begin : g_first
      assign d_in = s1_q;
    end else begin : g_next
      assign d_in = dly[i-1];
    end
    mp64_pipe_reg u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pipe_en),
      .flush (flush),
      .d     (d_in),
      .q     (dly[i])
    );
  end

  if (LATENCY > 2) begin : g_out_dly
    assign last = dly[LATENCY-3];
  end else begin : g_out_acc
    assign last = s1_q;
  end

  assign bus.out_valid  = last.valid;
  assign bus.out_result = last.result[RW-1:0];
  assign bus.out_ovf    = last.ovf;
  assign bus.out_tag    = last.tag[TAG_W-1:0];

  always_comb begin
    busy = s0_q.valid | s1_q.valid;
    for (int i = 0; i < LATENCY - 2; i++) begin
      busy = busy | dly[i].valid;
    end
  end

  // Fields that only ride along to the last stage.
  assign unused = ^{last, prod};

endmodule

// File: tb/tb_mp64_mul_pipe.sv
// Scoreboard bench for mp64_mul_pipe: directed vectors, stalls,
// flush and asynchronous reset with operations in flight.
module tb_mp64_mul_pipe;

  localparam int W  = 64;
  localparam int L  = 4;
  localparam int TW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic busy;

  mp64_mul_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  mp64_mul_pipe #(
    .WIDTH   (W),
    .LATENCY (L),
    .TAG_W   (TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] r;
    logic         o;
    logic [3:0]   t;
  } exp_t;

  exp_t q[$];
  int   errs   = 0;
  int   checks = 0;

  function automatic void chk(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  task automatic send(
    input logic [2:0]   op,
    input logic [63:0]  a,
    input logic [63:0]  b,
    input logic [127:0] c,
    input logic [3:0]   tag,
    input logic [127:0] er,
    input logic         eo,
    input logic         keep
  );
    int   n;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_c     = c;
    bus.in_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: tag %0d not accepted, want accept", tag);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (keep) begin
        e.r = er;
        e.o = eo;
        e.t = tag;
        q.push_back(e);
      end
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic lat_check(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    chk(nm, 128'(n), 128'(L));
    @(posedge clk);
    #1;
  endtask

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_out: got tag %0d result %h, want none",
                   bus.out_tag, bus.out_result);
        end else begin
          e = q.pop_front();
          chk("result", bus.out_result, e.r);
          chk("ovf", 128'(bus.out_ovf), 128'(e.o));
          chk("tag", 128'(bus.out_tag), 128'(e.t));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin : main
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_c      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_result", bus.out_result, 128'(0));
    chk("rst_ovf", 128'(bus.out_ovf), 128'(0));
    chk("rst_tag", 128'(bus.out_tag), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(3'b000, '1, 64'd2, 128'h0, 4'd5,
         128'h1_FFFFFFFF_FFFFFFFE, 1'b0, 1'b1);
    lat_check("latency");

    send(3'b001, 64'hFFFFFFFF_FFFFFFFD, 64'd5, 128'h0, 4'd1,
         128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFF1, 1'b0, 1'b1);
    send(3'b010, '1, 64'd2, 128'h0, 4'd2,
         128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0, 1'b1);
    send(3'b011, '1, 64'd2, 128'h0, 4'd3,
         128'h1_FFFFFFFF_FFFFFFFE, 1'b0, 1'b1);
    send(3'b000, 64'd3, 64'd4, 128'hDEAD, 4'd4,
         128'd12, 1'b0, 1'b1);
    send(3'b100, 64'd1, 64'd1, '1, 4'd6,
         128'h0, 1'b1, 1'b1);
    send(3'b101, 64'd1, 64'd1,
         128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 4'd7,
         128'h80000000_00000000_00000000_00000000, 1'b1, 1'b1);
    send(3'b101, '1, 64'd1, 128'd5, 4'd8,
         128'd4, 1'b0, 1'b1);
    send(3'b110, '1, 64'd1, 128'd1, 4'd9,
         128'd0, 1'b0, 1'b1);
    repeat (8) @(posedge clk);
    #1;

    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(3'b000, 64'(i + 1), 64'(i + 3), 128'h0, 4'(i),
               128'((i + 1) * (i + 3)), 1'b0, 1'b1);
        end
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pre_stall_in_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
          @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post_stall_in_ready", 128'(bus.in_ready), 128'(1));
      end
    join
    repeat (10) @(posedge clk);
    #1;

    send(3'b000, 64'd2, 64'd2, 128'h0, 4'd1, 128'd4, 1'b0, 1'b0);
    send(3'b000, 64'd3, 64'd3, 128'h0, 4'd2, 128'd9, 1'b0, 1'b0);
    send(3'b000, 64'd4, 64'd4, 128'h0, 4'd3, 128'd16, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_op    = 3'b000;
    bus.in_a     = 64'd5;
    bus.in_b     = 64'd5;
    bus.in_tag   = 4'd9;
    flush        = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_busy", 128'(busy), 128'(0));
    chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1;
    send(3'b000, 64'd6, 64'd7, 128'h0, 4'd7, 128'd42, 1'b0, 1'b1);
    lat_check("flush_latency");
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      send(3'b000, 64'(i + 9), 64'd3, 128'h0, 4'(i + 10),
           128'((i + 9) * 3), 1'b0, 1'b0);
    end
    chk("pre_rst_out_valid", 128'(bus.out_valid), 128'(1));
    chk("pre_rst_busy", 128'(busy), 128'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_result", bus.out_result, 128'(0));
    chk("mid_rst_ovf", 128'(bus.out_ovf), 128'(0));
    chk("mid_rst_tag", 128'(bus.out_tag), 128'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(3'b000, 64'd8, 64'd8, 128'h0, 4'd12, 128'd64, 1'b0, 1'b1);
    lat_check("rst_recover_latency");
    repeat (6) @(posedge clk);

    chk("drain", 128'(q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
